// File: rtl/ps2_device_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_device_transmitter
// Purpose  : Device (keyboard) side of a PS/2 link. Bytes written by a bus
//            master are queued in a 16-entry FIFO. Each byte is sent to the
//            host as an 11-bit frame: start 0, 8 data bits LSB first, odd
//            parity, stop 1. The block generates the PS/2 clock itself. It
//            backs off when the host inhibits the clock, and it holds off
//            while the host signals request-to-send.
// Ports    : clk        system clock, all logic on posedge
//            rst_n      asynchronous active-low reset
//            write      one-cycle strobe, push in_bus[7:0] into the FIFO
//            in_bus     write data, bits [15:8] ignored
//            read       one-cycle strobe, capture status and clear overflow
//            out_bus    status {6'b0, overflow, host_rts, busy, full, empty,
//                       count[4:0]}
//            interrupt  FIFO empty and transmitter idle
//            ps2_clk    open-drain PS/2 clock (driven 0 or released)
//            ps2_data   open-drain PS/2 data  (driven 0 or released)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_device_transmitter #(
  parameter int HALF = 2000,  // clk cycles per PS/2 clock half-period
  parameter int IDLE = 2500   // idle-line cycles required before a frame
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [15:0] in_bus,
  input  logic        read,
  output logic [15:0] out_bus,
  output logic        interrupt,
  inout  wire         ps2_clk,
  inout  wire         ps2_data
);

  localparam int PW = $clog2(HALF + 1);
  localparam int IW = $clog2(IDLE + 1);

  localparam logic [PW-1:0] HALF_END = PW'(HALF - 1);
  localparam logic [PW-1:0] HALF_MID = PW'(HALF / 2);
  localparam logic [PW-1:0] INH_MIN  = PW'(3);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE);
  localparam logic [3:0]    LAST_IDX = 4'd10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    next_state;

  logic          sclk_m, sclk, sdat_m, sdat;
  logic [IW-1:0] idle_cnt;

  logic [7:0]    mem [16];
  logic [3:0]    rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic          overflow;

  logic [7:0]    shift;
  logic          parity;
  logic [3:0]    index;
  logic [PW-1:0] phase;
  logic          data_bit;

  logic          full, empty, push, pop, busy, host_rts;
  logic          drive_clk_low, drive_dat_low;
  logic          unused_bits;

  assign unused_bits = ^in_bus[15:8];

  assign full     = (count == 5'd16);
  assign empty    = (count == 5'd0);
  assign push     = write && !full;
  // Frame is only complete once the 11th clock-low phase has finished.
  assign pop      = (state == S_LOW) && (phase == HALF_END) && (index == LAST_IDX);
  assign host_rts = sclk && !sdat && !busy;
  assign interrupt = empty && !busy;

  // Line synchronisers; reset to the pulled-up level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m <= 1'b1;
      sclk   <= 1'b1;
      sdat_m <= 1'b1;
      sdat   <= 1'b1;
    end else begin
      sclk_m <= ps2_clk;
      sclk   <= sclk_m;
      sdat_m <= ps2_data;
      sdat   <= sdat_m;
    end
  end

  // Idle-line counter, saturating; restarted after an abort so the host
  // gets a full idle window before the retransmission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == S_ABORT) begin
      idle_cnt <= '0;
    end else if (sclk && sdat) begin
      if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  // FIFO storage carries no reset; contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_bus[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      // A dropped write wins over a simultaneous read clear.
      if (write && full) begin
        overflow <= 1'b1;
      end else if (read) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bus <= '0;
    end else if (read) begin
      out_bus <= {6'b0, overflow, host_rts, busy, full, empty, count};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (!empty && (idle_cnt == IDLE_MAX)) next_state = S_LOAD;
      end
      S_LOAD: next_state = S_HIGH;
      S_HIGH: begin
        // The first few cycles are skipped because the synchroniser still
        // shows our own low clock from the previous phase.
        if ((phase >= INH_MIN) && !sclk) begin
          next_state = S_ABORT;
        end else if (phase == HALF_END) begin
          next_state = S_LOW;
        end
      end
      S_LOW: begin
        if (phase == HALF_END) begin
          next_state = (index == LAST_IDX) ? S_DONE : S_HIGH;
        end
      end
      S_ABORT: next_state = S_IDLE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = (state != S_IDLE);
    drive_clk_low = (state == S_LOW);
    drive_dat_low = ((state == S_HIGH) || (state == S_LOW)) && !data_bit;
  end

  assign ps2_clk  = drive_clk_low ? 1'b0 : 1'bz;
  assign ps2_data = drive_dat_low ? 1'b0 : 1'bz;

  // Frame datapath: phase timer, bit index and the serialiser. The data
  // bits are shifted out of 'shift' one per frame bit, so the FIFO head is
  // left intact for a retransmission after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      index    <= '0;
      data_bit <= 1'b1;
    end else begin
      if (((state == S_HIGH) || (state == S_LOW)) && (next_state == state)) begin
        phase <= phase + PW'(1);
      end else begin
        phase <= '0;
      end
      case (state)
        S_LOAD: begin
          shift    <= mem[rd_ptr];
          parity   <= ~^mem[rd_ptr];
          index    <= '0;
          data_bit <= 1'b1;
        end
        S_HIGH: begin
          if (phase == HALF_MID) begin
            if (index == 4'd0) begin
              data_bit <= 1'b0;
            end else if (index <= 4'd8) begin
              data_bit <= shift[0];
              shift    <= shift >> 1;
            end else if (index == 4'd9) begin
              data_bit <= parity;
            end else begin
              data_bit <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if ((phase == HALF_END) && (index != LAST_IDX)) begin
            index <= index + 4'd1;
          end
        end
        default: data_bit <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire
